tl_display_scan: RTL and testbench

//  Consumer side of the traffic-light controller outputs: takes the six lamp lines and the
//  two BCD countdown digits (l_7_A, l_7_B) and drives one shared time-multiplexed 7-segment bus.

---
 rtl/tl_display_scan_if.sv | 40 ++++
 rtl/tl_display_scan.sv | 159 +++++++++++++++
 tb/tb_tl_display_scan.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : tl_display_scan_if
// Purpose  : Bundle between the traffic-light controller outputs and the
//            shared 7-segment scan driver: six lamp lines, two BCD countdown
//            digits, the fault clear strobe, and the driven segment/digit/fault
//            outputs.
// Revision : 1.0  initial release
// ============================================================================
interface tl_display_scan_if;
  logic       l_red_A;
  logic       l_yellow_A;
  logic       l_green_A;
  logic       l_red_B;
  logic       l_yellow_B;
  logic       l_green_B;
  logic [3:0] l_7_A;
  logic [3:0] l_7_B;
  logic       fault_clr;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic       fault;

  // Controller / board side: drives lamps and digits, observes the display
  modport master (
    output l_red_A, l_yellow_A, l_green_A,
    output l_red_B, l_yellow_B, l_green_B,
    output l_7_A, l_7_B, fault_clr,
    input  seg, dig_en, fault
  );

  // Scan driver side
  modport slave (
    input  l_red_A, l_yellow_A, l_green_A,
    input  l_red_B, l_yellow_B, l_green_B,
    input  l_7_A, l_7_B, fault_clr,
    output seg, dig_en, fault
  );
endinterface
`default_nettype wire

// File: rtl/tl_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tl_display_scan
// Purpose  : Time-multiplexes the two BCD countdown digits onto one shared
//            7-segment bus (A slot, gap, B slot, gap), decoding BCD to
//            segments with registered, ghost-free outputs.
// Option   : define TL_FAULT_MON_EN to compile in the lamp-conflict monitor
//            (sticky fault flag, 'F' shown on both digits while set).
// Revision : 1.0  initial release
// ============================================================================
module tl_display_scan #(
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  wire logic        clk_f,
  input  wire logic        rst,
  tl_display_scan_if.slave bus
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]  DIG_OFF  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [6:0]  GLYPH_F  = 7'h71;

  typedef enum logic [1:0] {
    GAP_B  = 2'd0,
    SCAN_A = 2'd1,
    GAP_A  = 2'd2,
    SCAN_B = 2'd3
  } scan_state_t;

  scan_state_t state, state_nx;
  logic [15:0] div_cnt, div_nx;
  logic        tick;
  logic [3:0]  da_q, db_q, shown_q, shown_nx;
  logic [6:0]  seg_q, seg_ah_nx, glyph;
  logic [1:0]  dig_q, dig_ah_nx;
  logic        fault_nx;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;   // non-BCD codes show a dash
    endcase
  endfunction

  // Next-state, snapshot and active-high output pattern for the coming cycle
  always_comb begin
    tick     = (div_cnt == DIV_LAST);
    div_nx   = tick ? 16'd0 : div_cnt + 16'd1;
    state_nx = state;
    if (tick) begin
      case (state)
        GAP_B:  state_nx = SCAN_A;
        SCAN_A: state_nx = GAP_A;
        GAP_A:  state_nx = SCAN_B;
        SCAN_B: state_nx = GAP_B;
      endcase
    end
    // Freeze the digit at slot entry so mid-slot input changes never tear
    shown_nx = shown_q;
    if (tick && state_nx == SCAN_A)
      shown_nx = da_q;
    else if (tick && state_nx == SCAN_B)
      shown_nx = db_q;
    glyph     = fault_nx ? GLYPH_F : bcd_to_seg(shown_nx);
    seg_ah_nx = 7'h00;
    dig_ah_nx = 2'b00;
    case (state_nx)
      SCAN_A: begin
        seg_ah_nx = glyph;
        dig_ah_nx = 2'b01;
      end
      SCAN_B: begin
        seg_ah_nx = glyph;
        dig_ah_nx = 2'b10;
      end
      default: ;
    endcase
  end

  // Scan FSM, digit sampling and output flops; seg/dig_en follow the state edge
  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      state   <= GAP_B;
      div_cnt <= '0;
      da_q    <= '0;
      db_q    <= '0;
      shown_q <= '0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      da_q    <= bus.l_7_A;
      db_q    <= bus.l_7_B;
      shown_q <= shown_nx;
      seg_q   <= SEG_ACTIVE_LOW ? ~seg_ah_nx : seg_ah_nx;
      dig_q   <= SEG_ACTIVE_LOW ? ~dig_ah_nx : dig_ah_nx;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.dig_en = dig_q;

`ifdef TL_FAULT_MON_EN
  logic       cond;
  logic       fault_q;
  logic [1:0] filt_q, filt_nx;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Lamp conflict detection, two-cycle filter and sticky fault with guarded clear
  always_comb begin
    cond = !one_hot3({bus.l_red_A, bus.l_yellow_A, bus.l_green_A}) ||
           !one_hot3({bus.l_red_B, bus.l_yellow_B, bus.l_green_B}) ||
           ((bus.l_green_A | bus.l_yellow_A) & (bus.l_green_B | bus.l_yellow_B));
    filt_nx  = cond ? ((filt_q == 2'd2) ? 2'd2 : filt_q + 2'd1) : 2'd0;
    fault_nx = fault_q;
    if (filt_nx == 2'd2)
      fault_nx = 1'b1;
    else if (bus.fault_clr && !cond)
      fault_nx = 1'b0;
  end

  // Fault filter and flag registers
  always_ff @(posedge clk_f or posedge rst) begin
    if (rst) begin
      filt_q  <= 2'd0;
      fault_q <= 1'b0;
    end else begin
      filt_q  <= filt_nx;
      fault_q <= fault_nx;
    end
  end

  assign bus.fault = fault_q;
`else
  logic unused_mon;
  assign unused_mon = ^{bus.l_red_A, bus.l_yellow_A, bus.l_green_A,
                        bus.l_red_B, bus.l_yellow_B, bus.l_green_B,
                        bus.fault_clr};
  assign fault_nx   = 1'b0;
  assign bus.fault  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_display_scan
// Purpose  : Self-checking bench for tl_display_scan. Two instances share the
//            same stimulus: SCAN_DIV=4 active-low and SCAN_DIV=1 active-high.
//            Expected outputs come from a slot/time-based reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tl_display_scan;

  logic       clk_f = 1'b0;
  logic       rst   = 1'b1;
  logic       l_red_A, l_yellow_A, l_green_A;
  logic       l_red_B, l_yellow_B, l_green_B;
  logic [3:0] l_7_A, l_7_B;
  logic       fault_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_f = ~clk_f;

  tl_display_scan_if bus4();
  tl_display_scan_if bus1();

  assign bus4.l_red_A = l_red_A;    assign bus1.l_red_A = l_red_A;
  assign bus4.l_yellow_A = l_yellow_A; assign bus1.l_yellow_A = l_yellow_A;
  assign bus4.l_green_A = l_green_A;  assign bus1.l_green_A = l_green_A;
  assign bus4.l_red_B = l_red_B;    assign bus1.l_red_B = l_red_B;
  assign bus4.l_yellow_B = l_yellow_B; assign bus1.l_yellow_B = l_yellow_B;
  assign bus4.l_green_B = l_green_B;  assign bus1.l_green_B = l_green_B;
  assign bus4.l_7_A = l_7_A;        assign bus1.l_7_A = l_7_A;
  assign bus4.l_7_B = l_7_B;        assign bus1.l_7_B = l_7_B;
  assign bus4.fault_clr = fault_clr; assign bus1.fault_clr = fault_clr;

  tl_display_scan #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut4 (
    .clk_f(clk_f), .rst(rst), .bus(bus4));
  tl_display_scan #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b0)) dut1 (
    .clk_f(clk_f), .rst(rst), .bus(bus1));

  // ---------------- reference model ----------------
  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  int         n;          // clock edges since reset release
  logic [3:0] a_prev, b_prev, shown4, shown1;
  logic       fault_m;
  int         consec;

  function automatic logic lamp_conflict();
    return ($countones({l_red_A, l_yellow_A, l_green_A}) != 1) ||
           ($countones({l_red_B, l_yellow_B, l_green_B}) != 1) ||
           ((l_green_A || l_yellow_A) && (l_green_B || l_yellow_B));
  endfunction

  task automatic model_reset();
    n = 0; a_prev = 0; b_prev = 0; shown4 = 0; shown1 = 0; fault_m = 0; consec = 0;
  endtask

  task automatic model_edge();
    logic cond;
    n++;
    // slot index = (edges / slot length) mod 4 : 0 gap, 1 A, 2 gap, 3 B
    if (n % 4 == 0) begin
      if ((n / 4) % 4 == 1) shown4 = a_prev;
      else if ((n / 4) % 4 == 3) shown4 = b_prev;
    end
    if (n % 4 == 1) shown1 = a_prev;
    else if (n % 4 == 3) shown1 = b_prev;
    a_prev = l_7_A;
    b_prev = l_7_B;
`ifdef TL_FAULT_MON_EN
    cond   = lamp_conflict();
    consec = cond ? consec + 1 : 0;
    if (consec >= 2) fault_m = 1'b1;
    else if (fault_clr && !cond) fault_m = 1'b0;
`else
    cond = 1'b0;
    if (cond) fault_m = 1'b1;
`endif
  endtask

  function automatic logic [19:0] exp_vec();
    int s4 = (n / 4) % 4;
    int s1 = n % 4;
    logic [6:0] sg4 = 7'h00, sg1 = 7'h00;
    logic [1:0] d4 = 2'b00, d1 = 2'b00;
    if (s4 == 1 || s4 == 3) begin
      sg4 = fault_m ? 7'h71 : dec_tab[shown4];
      d4  = (s4 == 1) ? 2'b01 : 2'b10;
    end
    if (s1 == 1 || s1 == 3) begin
      sg1 = fault_m ? 7'h71 : dec_tab[shown1];
      d1  = (s1 == 1) ? 2'b01 : 2'b10;
    end
    return {~sg4, ~d4, fault_m, sg1, d1, fault_m};
  endfunction

  function automatic logic [19:0] obs();
    return {bus4.seg, bus4.dig_en, bus4.fault, bus1.seg, bus1.dig_en, bus1.fault};
  endfunction

  // one clock edge: advance the model, return at the following falling edge
  task automatic step();
    @(posedge clk_f);
    model_edge();
    @(negedge clk_f);
  endtask

  task automatic set_lamps(input logic [5:0] v);
    {l_red_A, l_yellow_A, l_green_A, l_red_B, l_yellow_B, l_green_B} = v;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_lamps(6'b001_100);
    l_7_A = 4'd3; l_7_B = 4'd9; fault_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_f);
    n_checks += 4;
    if (bus4.seg !== 7'h7F || bus4.dig_en !== 2'b11) begin
      n_fail++; $display("FAIL reset_lo got seg=%h dig=%b exp seg=7f dig=11", bus4.seg, bus4.dig_en);
    end
    if (bus1.seg !== 7'h00 || bus1.dig_en !== 2'b00) begin
      n_fail++; $display("FAIL reset_hi got seg=%h dig=%b exp seg=00 dig=00", bus1.seg, bus1.dig_en);
    end
    if (bus4.fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_fault4 got %b exp 0", bus4.fault);
    end
    if (bus1.fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_fault1 got %b exp 0", bus1.fault);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan_basic();
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL scan n=%0d got=%h exp=%h", n, obs(), exp_vec());
      end
      if (n == 4 || n == 20) begin
        n_checks++;
        if (bus4.dig_en !== 2'b10 || bus4.seg !== 7'h30) begin
          n_fail++; $display("FAIL scan_A n=%0d got dig=%b seg=%h exp dig=10 seg=30", n, bus4.dig_en, bus4.seg);
        end
      end
      if (n == 3 || n == 8) begin
        n_checks++;
        if (bus4.dig_en !== 2'b11 || bus4.seg !== 7'h7F) begin
          n_fail++; $display("FAIL scan_gap n=%0d got dig=%b seg=%h exp dig=11 seg=7f", n, bus4.dig_en, bus4.seg);
        end
      end
      if (n == 12) begin
        n_checks++;
        if (bus4.dig_en !== 2'b01 || bus4.seg !== 7'h10) begin
          n_fail++; $display("FAIL scan_B got dig=%b seg=%h exp dig=01 seg=10", bus4.dig_en, bus4.seg);
        end
      end
      if (n == 5 || n == 7 || n == 6) begin
        n_checks++;
        if ({bus1.dig_en, bus1.seg} !== ((n == 5) ? {2'b01, 7'h4F} : (n == 7) ? {2'b10, 7'h6F} : {2'b00, 7'h00})) begin
          n_fail++; $display("FAIL div1 n=%0d got dig=%b seg=%h", n, bus1.dig_en, bus1.seg);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    l_7_A = 4'd5;
    while (n < 53) begin
      step();
      if (n == 36) l_7_A = 4'd4;
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL snap n=%0d got=%h exp=%h", n, obs(), exp_vec());
      end
      if (n >= 36 && n <= 39) begin
        n_checks++;
        if (bus4.seg !== 7'h12 || bus4.dig_en !== 2'b10) begin
          n_fail++; $display("FAIL snap_hold n=%0d got seg=%h exp seg=12", n, bus4.seg);
        end
      end
      if (n == 52) begin
        n_checks++;
        if (bus4.seg !== 7'h19) begin
          n_fail++; $display("FAIL snap_next got seg=%h exp seg=19", bus4.seg);
        end
      end
    end
  endtask

  task automatic test_dash();
    l_7_B = 4'hC;
    while (n < 70) begin
      step();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL dash n=%0d got=%h exp=%h", n, obs(), exp_vec());
      end
      if (n == 60 || n == 68) begin
        n_checks++;
        if (bus4.seg !== ((n == 60) ? 7'h3F : 7'h19)) begin
          n_fail++; $display("FAIL dash_slot n=%0d got seg=%h", n, bus4.seg);
        end
      end
    end
  endtask

  task automatic test_fault();
    logic exp_f;
    int   k;
    logic [5:0] seq [8] = '{6'b001_001, 6'b001_100, 6'b001_001, 6'b001_001,
                            6'b001_001, 6'b001_100, 6'b001_100, 6'b001_100};
    logic       clr [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef TL_FAULT_MON_EN
    logic exp_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    logic exp_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 8; i++) begin
      set_lamps(seq[i]);
      fault_clr = clr[i];
      step();
      exp_f = exp_tab[i];
      n_checks++;
      if (bus4.fault !== exp_f || bus1.fault !== exp_f) begin
        n_fail++; $display("FAIL fault_seq step=%0d got %b/%b exp %b", i, bus4.fault, bus1.fault, exp_f);
      end
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL fault_model n=%0d got=%h exp=%h", n, obs(), exp_vec());
      end
    end
    // hold a conflict into the next A slot: the digit shows 'F' with the monitor
    set_lamps(6'b001_001);
    fault_clr = 1'b0;
    k = 0;
    while (((n / 4) % 4 != 1) && k < 20) begin
      step();
      k++;
    end
`ifdef TL_FAULT_MON_EN
    exp_f = 1'b1;
`else
    exp_f = 1'b0;
`endif
    n_checks++;
    if (k >= 20 || bus4.seg !== (exp_f ? 7'h0E : ~dec_tab[shown4]) || bus4.fault !== exp_f) begin
      n_fail++; $display("FAIL fault_glyph got seg=%h fault=%b exp fault=%b", bus4.seg, bus4.fault, exp_f);
    end
    set_lamps(6'b001_100);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    n_checks++;
    if (bus4.fault !== 1'b0 || obs() !== exp_vec()) begin
      n_fail++; $display("FAIL fault_clear got fault=%b exp 0", bus4.fault);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    while ((n / 4) % 4 != 3 || n % 4 != 1) begin
      step();
      k++;
      if (k > 20) break;
    end
    #2 rst = 1'b1;
    #1;
    n_checks += 3;
    if (k > 20) begin
      n_fail++; $display("FAIL mid_reach got k=%0d exp <=20", k);
    end
    if (bus4.seg !== 7'h7F || bus4.dig_en !== 2'b11 || bus4.fault !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst4 got seg=%h dig=%b fault=%b exp 7f/11/0", bus4.seg, bus4.dig_en, bus4.fault);
    end
    if (bus1.seg !== 7'h00 || bus1.dig_en !== 2'b00 || bus1.fault !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst1 got seg=%h dig=%b fault=%b exp 00/00/0", bus1.seg, bus1.dig_en, bus1.fault);
    end
    model_reset();
    @(negedge clk_f);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL post_rst n=%0d got=%h exp=%h", n, obs(), exp_vec());
      end
      if (n == 3 || n == 4) begin
        n_checks++;
        if (bus4.dig_en !== ((n == 3) ? 2'b11 : 2'b10)) begin
          n_fail++; $display("FAIL first_A n=%0d got dig=%b", n, bus4.dig_en);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] legal [5] = '{6'b001_100, 6'b010_100, 6'b100_001, 6'b100_010, 6'b100_100};
    for (int i = 0; i < 400; i++) begin
      l_7_A = 4'($urandom_range(0, 15));
      l_7_B = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 8) set_lamps(legal[$urandom_range(0, 4)]);
      else set_lamps(6'($urandom));
      fault_clr = ($urandom_range(0, 3) == 0);
      step();
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++; $display("FAIL random n=%0d got=%h exp=%h", n, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_snapshot();
    test_dash();
    test_fault();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
